// File: rtl/rr_multi_issue_arbiter.sv
// Round-robin multi-grant issue arbiter: steers up to REQS ready requesters onto
// REQS valid/ready issue ports, holding a stalled grant until its port accepts it.
module rr_multi_issue_arbiter #(
    parameter int WIDTH = 8,
    parameter int REQS  = 2,
    parameter int PTR_W = $clog2(WIDTH)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          req,
    input  logic [REQS-1:0]           port_ready,
    output logic [REQS-1:0]           port_valid,
    output logic [REQS*WIDTH-1:0]     gnt_bus,
    output logic [WIDTH-1:0]          gnt,
    output logic [$clog2(REQS+1)-1:0] num_issued,
    output logic                      empty
);

    localparam int CNT_W = $clog2(REQS+1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } port_state_t;

    port_state_t      state_q    [REQS];
    port_state_t      state_d    [REQS];
    logic [PTR_W-1:0] held_idx_q [REQS];
    logic [PTR_W-1:0] held_idx_d [REQS];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    logic [REQS-1:0]  sel_vld;
    logic [PTR_W-1:0] sel_idx [REQS];
    logic [PTR_W-1:0] sel_pos [REQS];
    logic [WIDTH-1:0] held_mask;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] rot_cand;

    function automatic logic [PTR_W-1:0] idx_add(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s >= WIDTH) s = s - WIDTH;
        return PTR_W'(s);
    endfunction

    function automatic logic [PTR_W-1:0] idx_sub(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
        int s;
        s = int'(a) - int'(b);
        if (s < 0) s = s + WIDTH;
        return PTR_W'(s);
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input logic [PTR_W-1:0] i);
        return WIDTH'(1) << i;
    endfunction

    // Selection: held ports replay their index; idle ports take candidates in rotated order.
    always_comb begin
        logic [WIDTH-1:0] avail;
        logic             found;

        held_mask = '0;
        sel_vld   = '0;
        for (int k = 0; k < REQS; k++) begin
            sel_idx[k] = '0;
            sel_pos[k] = '0;
            if (state_q[k] == HOLD) held_mask = held_mask | onehot(held_idx_q[k]);
        end

        cand = reset_n ? (req & ~held_mask) : '0;
        for (int j = 0; j < WIDTH; j++) begin
            rot_cand[j] = cand[idx_add(ptr_q, PTR_W'(j))];
        end

        avail = rot_cand;
        for (int k = 0; k < REQS; k++) begin
            found = 1'b0;
            if (state_q[k] == HOLD) begin
                sel_vld[k] = 1'b1;
                sel_idx[k] = held_idx_q[k];
                sel_pos[k] = idx_sub(held_idx_q[k], ptr_q);
            end else begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (!found && avail[j]) begin
                        found      = 1'b1;
                        sel_pos[k] = PTR_W'(j);
                    end
                end
                if (found) begin
                    avail[sel_pos[k]] = 1'b0;
                    sel_vld[k]        = 1'b1;
                    sel_idx[k]        = idx_add(ptr_q, sel_pos[k]);
                end
            end
        end
    end

    // port_ready reaches only num_issued here, never the grant outputs.
    always_comb begin
        gnt_bus    = '0;
        gnt        = '0;
        num_issued = '0;
        for (int k = 0; k < REQS; k++) begin
            if (sel_vld[k]) begin
                gnt_bus[k*WIDTH +: WIDTH] = onehot(sel_idx[k]);
                gnt                       = gnt | onehot(sel_idx[k]);
            end
            if (sel_vld[k] && port_ready[k]) num_issued = num_issued + CNT_W'(1);
        end
    end

    assign port_valid = sel_vld;
    assign empty      = !reset_n || ((req == '0) && (held_mask == '0));

    // Next state: per-port IDLE/HOLD and pointer past the furthest accepted grant.
    always_comb begin
        logic             any_acc;
        logic [PTR_W-1:0] best_pos;
        logic [PTR_W-1:0] best_idx;

        any_acc  = 1'b0;
        best_pos = '0;
        best_idx = '0;
        ptr_d    = ptr_q;
        for (int k = 0; k < REQS; k++) begin
            state_d[k]    = state_q[k];
            held_idx_d[k] = held_idx_q[k];
            if (state_q[k] == IDLE) begin
                if (sel_vld[k] && !port_ready[k]) begin
                    state_d[k]    = HOLD;
                    held_idx_d[k] = sel_idx[k];
                end
            end else if (port_ready[k]) begin
                state_d[k] = IDLE;
            end

            if (sel_vld[k] && port_ready[k] && (!any_acc || (sel_pos[k] > best_pos))) begin
                any_acc  = 1'b1;
                best_pos = sel_pos[k];
                best_idx = sel_idx[k];
            end
        end
        if (any_acc) ptr_d = idx_add(best_idx, PTR_W'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            for (int k = 0; k < REQS; k++) begin
                state_q[k]    <= IDLE;
                held_idx_q[k] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int k = 0; k < REQS; k++) begin
                state_q[k]    <= state_d[k];
                held_idx_q[k] <= held_idx_d[k];
            end
        end
    end

endmodule
